// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : 16x-oversampled UART receiver with start-bit validation,
//               3-sample majority voting, 5..8 data bits and runtime
//               none/even/odd parity. Each received character is tagged with
//               frame/parity error flags and buffered in a show-ahead FIFO
//               drained through a valid/ready handshake.
// Ports       : clk, rst (sync, active-high)
//               rx_i             asynchronous serial input, idle high
//               parity_mode_i    00/11 none, 01 even, 10 odd
//               rx_data_o        head character, LSB received first
//               rx_frame_err_o   head entry stop bit was 0
//               rx_parity_err_o  head entry parity mismatch
//               rx_valid_o       FIFO non-empty
//               rx_ready_i       pop when rx_valid_o && rx_ready_i
//               overrun_o        sticky dropped-character flag
//               clr_overrun_i    clears overrun_o
//               fifo_count_o     current FIFO occupancy
//               busy_o           receiver FSM not idle
//               break_o          (UART_RX_BREAK_EN only) 1-clk break pulse
// Options     : `define UART_RX_BREAK_EN to enable break detection.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLK_HZ      = 100000000,
    parameter int BAUD        = 115200,
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_i,
    input  logic [1:0]                    parity_mode_i,
    output logic [DATA_BITS-1:0]          rx_data_o,
    output logic                          rx_frame_err_o,
    output logic                          rx_parity_err_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic                          overrun_o,
    input  logic                          clr_overrun_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          busy_o
`ifdef UART_RX_BREAK_EN
    ,
    output logic                          break_o
`endif
);

    localparam int DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int EW  = DATA_BITS + 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [2:0] c_LAST_BIT = 3'(DATA_BITS - 1);

    // ---------------- synchronizer and edge detect ----------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_rx_s;

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_i};
            r_prev <= w_rx_s;
        end
    end

    // ---------------- FSM state ----------------
    logic [2:0]           r_state;
    logic [3:0]           r_samp_cnt;
    logic [2:0]           r_bit_cnt;
    logic [1:0]           r_votes;
    logic [DATA_BITS-1:0] r_shift;
    logic [1:0]           r_par_mode;
    logic                 r_par_err;
    logic [TW-1:0]        r_tick_cnt;
    logic                 w_tick;
    logic                 w_maj;
    logic                 w_par_en;
    logic                 w_start_edge;
    logic                 w_push;
    logic                 w_arm;

`ifdef UART_RX_BREAK_EN
    logic       r_par_bit;
    logic       r_brk_hold;
    logic [3:0] r_brk_cnt;
    logic       r_break;
    logic       w_is_break;

    // A break needs every sampled bit low, including parity if present.
    assign w_is_break = (r_shift == '0) && !w_maj && (!w_par_en || !r_par_bit);
    assign w_arm      = !r_brk_hold;
    assign break_o    = r_break;
`else
    assign w_arm      = 1'b1;
`endif

    assign w_tick       = (r_tick_cnt == TW'(DIV - 1));
    // The third vote is the live sample, so the decision is made at count 9.
    assign w_maj        = (r_votes[0] & r_votes[1]) | (r_votes[0] & w_rx_s) |
                          (r_votes[1] & w_rx_s);
    assign w_par_en     = r_par_mode[0] ^ r_par_mode[1];
    assign w_start_edge = (r_state == S_IDLE) && w_arm && r_prev && !w_rx_s;
    assign busy_o       = (r_state != S_IDLE);

`ifdef UART_RX_BREAK_EN
    assign w_push = (r_state == S_STOP) && w_tick && (r_samp_cnt == 4'd9) && !w_is_break;
`else
    assign w_push = (r_state == S_STOP) && w_tick && (r_samp_cnt == 4'd9);
`endif

    // Tick phase realigns to every accepted start edge.
    always_ff @(posedge clk) begin
        if (rst || w_start_edge || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_samp_cnt <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_votes    <= 2'b11;
            r_shift    <= '0;
            r_par_mode <= 2'b00;
            r_par_err  <= 1'b0;
`ifdef UART_RX_BREAK_EN
            r_par_bit  <= 1'b0;
            r_brk_hold <= 1'b0;
            r_brk_cnt  <= 4'd0;
            r_break    <= 1'b0;
`endif
        end else begin
`ifdef UART_RX_BREAK_EN
            r_break <= 1'b0;
            // After a break, wait for 16 consecutive high ticks before re-arming.
            if (r_brk_hold && w_tick) begin
                if (!w_rx_s) begin
                    r_brk_cnt <= 4'd0;
                end else if (r_brk_cnt == 4'd15) begin
                    r_brk_hold <= 1'b0;
                end else begin
                    r_brk_cnt <= r_brk_cnt + 4'd1;
                end
            end
`endif
            if (r_state == S_IDLE) begin
                if (w_start_edge) begin
                    r_state    <= S_START;
                    r_samp_cnt <= 4'd0;
                end
            end else if (w_tick) begin
                r_samp_cnt <= r_samp_cnt + 4'd1;
                if (r_samp_cnt == 4'd7) r_votes[0] <= w_rx_s;
                if (r_samp_cnt == 4'd8) r_votes[1] <= w_rx_s;
                case (r_state)
                    S_START: begin
                        if (r_samp_cnt == 4'd9) begin
                            if (w_maj) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_par_mode <= parity_mode_i;
                                r_par_err  <= 1'b0;
                            end
                        end else if (r_samp_cnt == 4'd15) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        if (r_samp_cnt == 4'd9) begin
                            r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                        end else if (r_samp_cnt == 4'd15) begin
                            if (r_bit_cnt == c_LAST_BIT) begin
                                r_state <= w_par_en ? S_PARITY : S_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (r_samp_cnt == 4'd9) begin
                            // mode[1] set means odd: invert the even-parity result.
                            r_par_err <= (^r_shift) ^ w_maj ^ r_par_mode[1];
`ifdef UART_RX_BREAK_EN
                            r_par_bit <= w_maj;
`endif
                        end else if (r_samp_cnt == 4'd15) begin
                            r_state <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        if (r_samp_cnt == 4'd9) begin
                            r_state <= S_IDLE;
`ifdef UART_RX_BREAK_EN
                            if (w_is_break) begin
                                r_break    <= 1'b1;
                                r_brk_hold <= 1'b1;
                                r_brk_cnt  <= 4'd0;
                            end
`endif
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // ---------------- show-ahead FIFO ----------------
    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overrun;
    logic          w_full;
    logic          w_do_pop;
    logic          w_do_push;
    logic [EW-1:0] w_head;
    logic [EW-1:0] w_push_word;

    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_do_pop    = rx_valid_o && rx_ready_i;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign w_do_push   = w_push && (!w_full || w_do_pop);
    assign w_push_word = {~w_maj, r_par_err & w_par_en, r_shift};
    assign w_head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= w_push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_do_pop) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun_i) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign rx_valid_o      = (r_count != '0);
    assign rx_data_o       = rx_valid_o ? w_head[DATA_BITS-1:0] : '0;
    assign rx_parity_err_o = rx_valid_o & w_head[DATA_BITS];
    assign rx_frame_err_o  = rx_valid_o & w_head[DATA_BITS+1];
    assign fifo_count_o    = r_count;
    assign overrun_o       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo. Runs with DIV=4 so the
//               whole sequence stays short; a queue of expected entries is
//               filled as frames are transmitted and drained as the DUT FIFO
//               is popped.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int CLK_HZ = 7372800;
    localparam int BAUD   = 115200;
    localparam int DIV    = (CLK_HZ + BAUD * 8) / (BAUD * 16);
    localparam int BIT    = 16 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_i;
    logic [1:0] parity_mode_i;
    logic [7:0] rx_data_o;
    logic       rx_frame_err_o;
    logic       rx_parity_err_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic       overrun_o;
    logic       clr_overrun_i;
    logic [4:0] fifo_count_o;
    logic       busy_o;
`ifdef UART_RX_BREAK_EN
    logic       break_o;
    int         brk_pulses = 0;
    always @(negedge clk) if (break_o) brk_pulses++;
`endif

    int checks = 0;
    int errors = 0;
    logic [9:0] sb[$];   // {frame_err, parity_err, data}

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .FIFO_DEPTH(16), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .rx_i(rx_i), .parity_mode_i(parity_mode_i),
        .rx_data_o(rx_data_o), .rx_frame_err_o(rx_frame_err_o),
        .rx_parity_err_o(rx_parity_err_o), .rx_valid_o(rx_valid_o),
        .rx_ready_i(rx_ready_i), .overrun_o(overrun_o),
        .clr_overrun_i(clr_overrun_i), .fifo_count_o(fifo_count_o),
        .busy_o(busy_o)
`ifdef UART_RX_BREAK_EN
        , .break_o(break_o)
`endif
    );

    function automatic logic exp_perr(input logic [1:0] mode, input logic [7:0] d, input logic pb);
        case (mode)
            2'b01:   return (^d) ^ pb;
            2'b10:   return ~((^d) ^ pb);
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive_bit(input logic b);
        rx_i = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic pb, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (par_en) drive_bit(pb);
        drive_bit(stop);
        rx_i = 1'b1;
    endtask

    task automatic pop_one();
        rx_ready_i = 1'b1;
        @(negedge clk);
        rx_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_i = 1'b1; parity_mode_i = 2'b00; rx_ready_i = 1'b0; clr_overrun_i = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({rx_valid_o, fifo_count_o, overrun_o, busy_o} !== 8'h00) begin
            errors++;
            $display("FAIL reset_status valid/count/ovr/busy=%b required 00000000",
                     {rx_valid_o, fifo_count_o, overrun_o, busy_o});
        end
        checks++;
        if ({rx_frame_err_o, rx_parity_err_o, rx_data_o} !== 10'h000) begin
            errors++;
            $display("FAIL reset_head got %h required 000", {rx_frame_err_o, rx_parity_err_o, rx_data_o});
        end
    endtask

    task automatic test_basic();
        logic [9:0] exp;
        parity_mode_i = 2'b00;
        sb.push_back({2'b00, 8'h55});
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        checks++;
        if (rx_valid_o !== 1'b1 || fifo_count_o !== 5'd1) begin
            errors++;
            $display("FAIL basic_count valid=%b count=%0d required 1/1", rx_valid_o, fifo_count_o);
        end
        exp = sb.pop_front();
        checks++;
        if ({rx_frame_err_o, rx_parity_err_o, rx_data_o} !== exp) begin
            errors++;
            $display("FAIL basic_head got %h required %h", {rx_frame_err_o, rx_parity_err_o, rx_data_o}, exp);
        end
        pop_one();
        checks++;
        if (rx_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_pop valid=%b required 0", rx_valid_o);
        end
    endtask

    task automatic test_parity();
        logic [9:0] exp;
        logic [1:0] modes [3] = '{2'b01, 2'b01, 2'b10};
        logic       pbits [3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            parity_mode_i = modes[i];
            sb.push_back({1'b0, exp_perr(modes[i], 8'hA7, pbits[i]), 8'hA7});
            send_frame(8'hA7, 1'b1, pbits[i], 1'b1);
        end
        parity_mode_i = 2'b00;
        checks++;
        if (fifo_count_o !== 5'd3) begin
            errors++;
            $display("FAIL parity_count got %0d required 3", fifo_count_o);
        end
        for (int i = 0; i < 3; i++) begin
            exp = sb.pop_front();
            checks++;
            if ({rx_frame_err_o, rx_parity_err_o, rx_data_o} !== exp) begin
                errors++;
                $display("FAIL parity_entry%0d got %h required %h", i,
                         {rx_frame_err_o, rx_parity_err_o, rx_data_o}, exp);
            end
            pop_one();
        end
    endtask

    task automatic test_glitch_frame();
        logic [9:0] exp;
        rx_i = 1'b0;
        repeat (4) @(negedge clk);
        rx_i = 1'b1;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_start busy=%b required 1", busy_o);
        end
        repeat (12 * DIV) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || fifo_count_o !== 5'd0) begin
            errors++;
            $display("FAIL glitch_reject busy=%b count=%0d required 0/0", busy_o, fifo_count_o);
        end
        repeat (BIT) @(negedge clk);
        sb.push_back({2'b10, 8'h3C});
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (BIT) @(negedge clk);
        exp = sb.pop_front();
        checks++;
        if (rx_valid_o !== 1'b1 || {rx_frame_err_o, rx_parity_err_o, rx_data_o} !== exp) begin
            errors++;
            $display("FAIL frame_err_entry valid=%b got %h required %h", rx_valid_o,
                     {rx_frame_err_o, rx_parity_err_o, rx_data_o}, exp);
        end
        pop_one();
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) sb.push_back({2'b00, 8'(i)});
            send_frame(8'(i), 1'b0, 1'b0, 1'b1);
        end
        checks++;
        if (fifo_count_o !== 5'd16 || overrun_o !== 1'b1) begin
            errors++;
            $display("FAIL overrun_state count=%0d ovr=%b required 16/1", fifo_count_o, overrun_o);
        end
        for (int i = 0; i < 16; i++) begin
            exp = sb.pop_front();
            checks++;
            if (rx_valid_o !== 1'b1 || {rx_frame_err_o, rx_parity_err_o, rx_data_o} !== exp) begin
                errors++;
                $display("FAIL drain_entry%0d valid=%b got %h required %h", i, rx_valid_o,
                         {rx_frame_err_o, rx_parity_err_o, rx_data_o}, exp);
            end
            pop_one();
        end
        checks++;
        if (fifo_count_o !== 5'd0 || overrun_o !== 1'b1) begin
            errors++;
            $display("FAIL drained_sticky count=%0d ovr=%b required 0/1", fifo_count_o, overrun_o);
        end
        clr_overrun_i = 1'b1;
        @(negedge clk);
        clr_overrun_i = 1'b0;
        checks++;
        if (overrun_o !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear ovr=%b required 0", overrun_o);
        end
    endtask

    task automatic test_break();
        logic [9:0] exp;
        parity_mode_i = 2'b00;
        rx_i = 1'b0;
        repeat (20 * BIT) @(negedge clk);
        rx_i = 1'b1;
        repeat (2 * BIT) @(negedge clk);
`ifdef UART_RX_BREAK_EN
        checks++;
        if (brk_pulses != 1 || fifo_count_o !== 5'd0) begin
            errors++;
            $display("FAIL break_detect pulses=%0d count=%0d required 1/0", brk_pulses, fifo_count_o);
        end
`else
        sb.push_back({2'b10, 8'h00});
        exp = sb.pop_front();
        checks++;
        if (fifo_count_o !== 5'd1 || {rx_frame_err_o, rx_parity_err_o, rx_data_o} !== exp) begin
            errors++;
            $display("FAIL break_entry count=%0d got %h required 1/%h", fifo_count_o,
                     {rx_frame_err_o, rx_parity_err_o, rx_data_o}, exp);
        end
        pop_one();
`endif
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] exp;
        logic [7:0] d = 8'hF0;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        rx_i = 1'b1;
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_count_o !== 5'd0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort count=%0d busy=%b required 0/0", fifo_count_o, busy_o);
        end
        repeat (BIT) @(negedge clk);
        sb.push_back({2'b00, 8'h81});
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        exp = sb.pop_front();
        checks++;
        if (rx_valid_o !== 1'b1 || {rx_frame_err_o, rx_parity_err_o, rx_data_o} !== exp) begin
            errors++;
            $display("FAIL after_reset_rx valid=%b got %h required %h", rx_valid_o,
                     {rx_frame_err_o, rx_parity_err_o, rx_data_o}, exp);
        end
        pop_one();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_glitch_frame();
        test_back_to_back();
        test_break();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Synthesizable UART receiver for BearCore-V.
- Oversamples the serial line at 16x, validates the start bit, and majority-votes each bit.
- Supports 5-8 data bits and runtime parity modes.
- Tags every received character with its frame and parity error status, then buffers it in a show-ahead FIFO drained by the core through a valid/ready handshake.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate; oversample tick divisor DIV = (CLK_HZ + BAUD*8)/(BAUD*16), must be >= 1.
- DATA_BITS, 8, character width, legal range 5..8.
- FIFO_DEPTH, 16, entries; must be a power of 2, >= 2.
- SYNC_STAGES, 2, number of rx_i synchronizer flops, >= 2.

Ports:
- clk  in  1  system clock; one clock domain for the whole block.
- rst  in  1  reset; synchronous and active-high.
- rx_i  in  1  asynchronous serial line; idle high.
- parity_mode_i  in  2  00 none, 01 even, 10 odd, 11 none; sampled at start-bit validation.
- rx_data_o  out  DATA_BITS  head-of-FIFO character, LSB received first.
- rx_frame_err_o  out  1  head entry's stop bit was sampled 0.
- rx_parity_err_o  out  1  head entry's parity mismatched.
- rx_valid_o  out  1  FIFO non-empty.
- rx_ready_i  in  1  pop when rx_valid_o && rx_ready_i.
- overrun_o  out  1  sticky: a character was dropped because the FIFO was full.
- clr_overrun_i  in  1  clears overrun_o.
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  current number of entries.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset values:
  - Synchronizer flops and the previous-sample flop reset to 1, so reset never produces a false falling edge.
  - FSM goes to IDLE; tick and bit counters go to 0.
  - FIFO pointers clear; rx_valid_o=0, fifo_count_o=0, overrun_o=0, busy_o=0.
  - rx_data_o and both error outputs read 0.
- Reset asserted mid-frame aborts the frame; the partial character is discarded.
- Tick generator: free-running counter 0..DIV-1 emits a 1-clk os_tick at DIV-1. It restarts at 0 on the start-edge detect, so tick phase aligns to the edge.
- A 4-bit sample counter counts os_ticks per bit. Bit value is the majority of synced samples at counts 7, 8 and 9. The bit ends at count 15.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: synced line falling edge (prev 1, now 0) -> START.
  - START: majority at count 9 is 1 -> false start, back to IDLE, nothing pushed. If 0, latch parity_mode_i; at count 15 -> DATA.
  - DATA: shift bits in LSB-first. After DATA_BITS bits go to PARITY if the latched mode is even or odd, else to STOP.
  - PARITY: even mode errors if XOR(data, parity bit) = 1; odd mode errors if it = 0. At count 15 -> STOP.
  - STOP: at count 9 (majority decided), push {frame_err, parity_err, data}, with frame_err = (stop == 0); go to IDLE the same cycle. The next start edge is accepted from the following clock, so back-to-back frames are tolerated.
- Characters with errors are still pushed; software decides whether to discard them.
- FIFO:
  - Show-ahead: outputs reflect the head entry combinationally from storage.
  - Push into an empty FIFO makes rx_valid_o=1 on the next clock.
  - Pop at the empty head is ignored.
  - Simultaneous push and pop: count is unchanged; this is legal even when full.
  - Push when full with no pop in the same cycle: the new character is dropped, FIFO contents are unchanged, and overrun_o is set.
  - Pointers wrap modulo FIFO_DEPTH; the count is tracked separately to distinguish full from empty.
- overrun_o:
  - clr_overrun_i clears it the next clock.
  - If a new overrun occurs in the same cycle as clr_overrun_i, set wins.

Optional Feature:
- Macro: UART_RX_BREAK_EN.
- Defined:
  - Adds output break_o (1 bit). It pulses high for 1 clk when a frame completes with all data bits 0, parity bit 0 (if enabled) and stop bit 0.
  - That frame is NOT pushed to the FIFO.
  - The FSM then holds in IDLE until the synced line has been high for 16 os_ticks before re-arming edge detection.
- Undefined:
  - No break_o port.
  - A break frame is pushed as data 0 with frame_err=1; normal edge rearm applies.

Test Plan:
- Defaults (DIV=54). Send 0x55 with parity none, rx_ready_i=0 -> rx_valid_o=1, rx_data_o=0x55, both error outputs 0, fifo_count_o=1. Assert ready for 1 clk -> rx_valid_o=0.
- parity_mode_i=01. Send 0xA7 with parity bit 1 -> parity_err=0. Repeat with parity bit 0 -> parity_err=1, data still 0xA7. With mode=10 and parity bit 0 -> parity_err=0.
- 4-clk low glitch on rx_i while idle -> no push, busy_o returns to 0 within 10 os_ticks. A stop bit driven 0 on 0x3C -> entry 0x3C with frame_err=1.
- 17 back-to-back characters 0x00..0x10 with ready=0 -> fifo_count_o=16, overrun_o=1, head=0x00. Popping all 16 yields 0x00..0x0F in order. clr_overrun_i -> overrun_o=0.
- Line held low 2 character times -> with UART_RX_BREAK_EN: break_o pulses once and fifo_count_o stays 0. Without the macro: a single entry 0x00 with frame_err=1.
- Assert rst mid-DATA of 0xF0 -> after release fifo_count_o=0, busy_o=0. A following 0x81 is received correctly.
